// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU sequencer: command op-codes, FSM state encoding and
// systolic-array geometry.
package mmu_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD_W = 2'b01;
  localparam logic [1:0] OP_MATMUL = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWload = 2'd1,
    StMmRun = 2'd2,
    StFin   = 2'd3
  } state_e;

  localparam int unsigned MMU_ROWS = 16;
  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned ACC_W    = 20;
  localparam int unsigned VEC_W    = MMU_ROWS * ELEM_W;  // one weight row / activation vector
  localparam int unsigned OUT_W    = MMU_ROWS * ACC_W;   // one result vector
  localparam int unsigned CNT_W    = 8;                  // width of the vector count

endpackage

// File: rtl/mmu_seq_addr_gen.sv
// Loadable wrapping address counter. load captures a base address and the index of the
// final access; step advances the address (wrapping modulo 2^AW) and the access index.
// last is high while the current access is the final one.
module mmu_seq_addr_gen #(
  parameter int unsigned AW    = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    base,
  input  logic [CNT_W-1:0] last_cnt,
  input  logic             step,
  output logic [AW-1:0]    addr,
  output logic             last
);

  logic [AW-1:0]    addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] max_q;

  // Address, access index and terminal index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
      max_q  <= '0;
    end else if (load) begin
      addr_q <= base;
      cnt_q  <= '0;
      max_q  <= last_cnt;
    end else if (step) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == max_q);

endmodule

// File: rtl/mmu_sequencer.sv
// Command sequencer for the 16x16 8-bit matrix multiply unit. Handles weight loading
// (16 rows shifted into the PE array) and matmul streaming (N activation vectors in,
// N result vectors written to the output buffer).
// Optional build macro MMU_SEQ_PERF_EN adds saturating busy-cycle and vector counters.
module mmu_sequencer
  import mmu_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned MMU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             wbuf_rd_en,
  output logic [AW-1:0]    wbuf_rd_addr,
  input  logic [VEC_W-1:0] wbuf_rd_data,
  output logic             abuf_rd_en,
  output logic [AW-1:0]    abuf_rd_addr,
  input  logic [VEC_W-1:0] abuf_rd_data,
  output logic             mmu_wen,
  output logic [VEC_W-1:0] mmu_win,
  output logic             mmu_mm_en,
  output logic [VEC_W-1:0] mmu_ain,
  input  logic [OUT_W-1:0] mmu_aout,
  output logic             obuf_wr_en,
  output logic [AW-1:0]    obuf_wr_addr,
  output logic [OUT_W-1:0] obuf_wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef MMU_SEQ_PERF_EN
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_vectors,
`endif
  output logic             w_loaded
);

  localparam int unsigned VLD_W = MMU_LAT + 1;

  state_e           state_q;
  logic             wbuf_rd_en_q;
  logic             abuf_rd_en_q;
  logic             wen_q;
  logic             mm_en_q;
  logic             done_q;
  logic             err_q;
  logic             w_loaded_q;
  // Bit 0: vector being fed to the MMU this cycle; bit MMU_LAT: its result is writable.
  logic [VLD_W-1:0] vld_q;
  logic [VLD_W-1:0] vld_d;

  logic             accept;
  logic             ctr_load;
  logic [CNT_W-1:0] rd_last_cnt;
  logic             rd_last;
  logic             wr_last;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    wr_addr;

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign accept      = cmd_valid && cmd_ready;
  assign ctr_load    = accept && ((cmd_op == OP_LOAD_W) || (cmd_op == OP_MATMUL));
  assign rd_last_cnt = (cmd_op == OP_LOAD_W) ? CNT_W'(MMU_ROWS - 1) : cmd_len;

  // Read-side address: weight rows or activation vectors, one per read cycle.
  mmu_seq_addr_gen #(
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_rd_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .base     (cmd_src),
    .last_cnt (rd_last_cnt),
    .step     (wbuf_rd_en_q || abuf_rd_en_q),
    .addr     (rd_addr),
    .last     (rd_last)
  );

  // Write-side address: one output-buffer entry per result vector.
  mmu_seq_addr_gen #(
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_wr_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .base     (cmd_dst),
    .last_cnt (cmd_len),
    .step     (vld_q[MMU_LAT]),
    .addr     (wr_addr),
    .last     (wr_last)
  );

  // In-flight pipeline: a read issued this cycle returns data (feed) next cycle.
  always_comb begin
    vld_d = (vld_q << 1) | VLD_W'(abuf_rd_en_q);
  end

  // Control FSM with all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wbuf_rd_en_q <= 1'b0;
      abuf_rd_en_q <= 1'b0;
      wen_q        <= 1'b0;
      mm_en_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      w_loaded_q   <= 1'b0;
      vld_q        <= '0;
    end else begin
      vld_q   <= vld_d;
      // Held from the first feed through the last write, gaps included.
      mm_en_q <= |vld_d;
      wen_q   <= wbuf_rd_en_q;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OP_NOP: begin
                state_q <= StFin;
                done_q  <= 1'b1;
              end
              OP_LOAD_W: begin
                state_q      <= StWload;
                wbuf_rd_en_q <= 1'b1;
              end
              OP_MATMUL: begin
                if (w_loaded_q) begin
                  state_q      <= StMmRun;
                  abuf_rd_en_q <= 1'b1;
                end else begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                end
              end
              OP_RSVD: begin
                state_q <= StFin;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
        StWload: begin
          if (wbuf_rd_en_q && rd_last) wbuf_rd_en_q <= 1'b0;
          // First read cycle: the first wen rises on this edge, old weights are gone.
          if (wbuf_rd_en_q && !wen_q) w_loaded_q <= 1'b0;
          // Reads finished and a wen is still pending: that is the 16th shift.
          if (wen_q && !wbuf_rd_en_q) begin
            state_q    <= StFin;
            done_q     <= 1'b1;
            w_loaded_q <= 1'b1;
          end
        end
        StMmRun: begin
          if (abuf_rd_en_q && rd_last) abuf_rd_en_q <= 1'b0;
          if (vld_q[MMU_LAT] && wr_last) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wbuf_rd_en   = wbuf_rd_en_q;
  assign wbuf_rd_addr = rd_addr;
  assign abuf_rd_en   = abuf_rd_en_q;
  assign abuf_rd_addr = rd_addr;
  assign mmu_wen      = wen_q;
  assign mmu_win      = wen_q ? wbuf_rd_data : '0;
  assign mmu_mm_en    = mm_en_q;
  assign mmu_ain      = vld_q[0] ? abuf_rd_data : '0;
  assign obuf_wr_en   = vld_q[MMU_LAT];
  assign obuf_wr_addr = wr_addr;
  // The result is valid in the write cycle itself, so it is forwarded, not re-registered.
  assign obuf_wr_data = vld_q[MMU_LAT] ? mmu_aout : '0;
  assign done         = done_q;
  assign err          = err_q;
  assign w_loaded     = w_loaded_q;

`ifdef MMU_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_vec_q;

  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_q <= '0;
      perf_vec_q  <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
      if (obuf_wr_en && (perf_vec_q != '1)) perf_vec_q <= perf_vec_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_vectors     = perf_vec_q;
`endif

endmodule
